// File: rtl/output_collector.sv
// output_collector: absorbs the convolution chip's per-cycle result stream
// into a FIFO (data plus x/y/ch), presents it to the host over valid/ready,
// and tracks per-frame result counts, frame completion and dropped results.
// Optional build macro: OUTPUT_COLLECTOR_RELU_EN clamps negative data to 0
// at push time.
module output_collector #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic signed [IO_DATA_WIDTH-1:0]         in_data,
  input  logic                                    in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   in_ch,
  input  logic                                    frame_start,
  input  logic [31:0]                             frame_len,
  output logic signed [IO_DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [$clog2(FIFO_DEPTH):0]             fill_level,
  output logic                                    almost_full,
  output logic                                    drop_err,
  output logic                                    frame_done,
  output logic [31:0]                             result_count
);

  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = IO_DATA_WIDTH + XW + YW + CHW;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [31:0]               result_count_q, result_count_d;
  logic [31:0]               len_q, len_d;
  logic                      drop_err_q, drop_err_d;
  logic [EW-1:0]             mem_q [FIFO_DEPTH];

  logic                      full, pop, push_acc, start_acc;
  logic [IO_DATA_WIDTH-1:0]  wr_data;
  logic [EW-1:0]             head;

  // Write-side data shaping and handshake decode.
  always_comb begin
`ifdef OUTPUT_COLLECTOR_RELU_EN
    wr_data = (in_data < 0) ? '0 : in_data;
`else
    wr_data = in_data;
`endif
    full      = (count_q == CW'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    push_acc  = in_valid && (state_q == COLLECT) && (!full || pop);
    start_acc = frame_start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Next-state logic for the frame FSM, pointers, counters and error flag.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    result_count_d = result_count_q;
    len_d          = len_q;
    drop_err_d     = drop_err_q;

    case (state_q)
      IDLE, DONE: if (start_acc) state_d = COLLECT;
      COLLECT:    if (result_count_q == len_q) state_d = DRAIN;
      DRAIN:      if (count_q == '0 && !push_acc) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    if (start_acc) begin
      result_count_d = '0;
      len_d          = frame_len;
      drop_err_d     = 1'b0;
    end else if (push_acc) begin
      result_count_d = result_count_q + 32'd1;
    end

    // A stray or overflowing result is lost; flag it even on a start cycle.
    if (in_valid && !push_acc) drop_err_d = 1'b1;

    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      result_count_q <= '0;
      len_q          <= '0;
      drop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      result_count_q <= result_count_d;
      len_q          <= len_d;
      drop_err_q     <= drop_err_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {wr_data, in_x, in_y, in_ch};
  end

  // Output decode: head fields are forced to zero whenever the FIFO is empty.
  always_comb begin
    out_valid    = (count_q != '0);
    head         = out_valid ? mem_q[rd_ptr_q] : '0;
    out_data     = head[EW-1 -: IO_DATA_WIDTH];
    out_x        = head[YW+CHW +: XW];
    out_y        = head[CHW +: YW];
    out_ch       = head[CHW-1:0];
    fill_level   = count_q;
    almost_full  = (count_q >= CW'(FIFO_DEPTH - ALMOST_FULL_MARGIN));
    drop_err     = drop_err_q;
    frame_done   = (state_q == DONE);
    result_count = result_count_q;
  end

endmodule
